// File: rtl/diag_avg.sv
// Per-channel block averager feeding the hex diagnostic dump.
// Holds four coherent averages while freeze is high; newest result wins.
module diag_avg #(
    parameter int DW    = 12,
    parameter int LOG2N = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [1:0]    in_chl,
    input  logic [DW-1:0] in_dat,
    input  logic          freeze,
    output logic [DW-1:0] a0,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic [DW-1:0] a3,
    output logic [3:0]    done
);

    localparam int AW = DW + LOG2N;

    typedef logic [AW-1:0]    acc_t;
    typedef logic [LOG2N-1:0] cnt_t;
    typedef logic [DW-1:0]    dat_t;

    acc_t       acc_q [4];
    acc_t       acc_d [4];
    cnt_t       cnt_q [4];
    cnt_t       cnt_d [4];
    dat_t       shd_q [4];
    dat_t       shd_d [4];
    dat_t       out_q [4];
    dat_t       out_d [4];
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] done_q;
    logic [3:0] done_d;

    acc_t sum;
    logic hit;
    logic last;

    always_comb begin
        sum    = acc_t'(in_dat);
        hit    = 1'b0;
        last   = 1'b0;
        pend_d = pend_q;
        done_d = '0;
        for (int c = 0; c < 4; c++) begin
            acc_d[c] = acc_q[c];
            cnt_d[c] = cnt_q[c];
            shd_d[c] = shd_q[c];
            out_d[c] = out_q[c];
            // Copy reads the old shadow; a same-cycle completion keeps pend.
            if (!freeze && pend_q[c]) begin
                out_d[c]  = shd_q[c];
                pend_d[c] = 1'b0;
            end
            hit  = in_valid && (in_chl == 2'(c));
            last = &cnt_q[c];
            sum  = acc_q[c] + acc_t'(in_dat);
            if (hit) begin
                if (last) begin
                    shd_d[c]  = sum[AW-1:LOG2N];
                    acc_d[c]  = '0;
                    cnt_d[c]  = '0;
                    pend_d[c] = 1'b1;
                    done_d[c] = 1'b1;
                end else begin
                    acc_d[c] = sum;
                    cnt_d[c] = cnt_q[c] + cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
                shd_q[c] <= '0;
                out_q[c] <= '0;
            end
            pend_q <= '0;
            done_q <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
                shd_q[c] <= shd_d[c];
                out_q[c] <= out_d[c];
            end
            pend_q <= pend_d;
            done_q <= done_d;
        end
    end

    assign a0   = out_q[0];
    assign a1   = out_q[1];
    assign a2   = out_q[2];
    assign a3   = out_q[3];
    assign done = done_q;

endmodule

// File: tb/tb_diag_avg.sv
// Directed bench for diag_avg: block averages, freeze, reset, overlap.
// Inputs change 1ns after posedge; outputs checked at the same point.
module tb_diag_avg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_chl = '0;
    logic [11:0] in_dat = '0;
    logic        freeze = 1'b0;
    logic [11:0] a0, a1, a2, a3;
    logic [3:0]  done;

    int checks = 0;
    int failures = 0;
    int dcnt = 0;
    logic saw111 = 1'b0;

    diag_avg dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_chl   (in_chl),
        .in_dat   (in_dat),
        .freeze   (freeze),
        .a0       (a0),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a2 == 12'h111) saw111 <= 1'b1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] ch, input logic [11:0] v);
        in_valid = 1'b1;
        in_chl   = ch;
        in_dat   = v;
        tick();
        in_valid = 1'b0;
        if (done != 4'b0) dcnt++;
    endtask

    task automatic block(input logic [1:0] ch, input logic [11:0] v);
        for (int i = 0; i < 64; i++) put(ch, v);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_a0", a0, 0);
        chk("rst_a3", a3, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // 1: constant block on ch0
        dcnt = 0;
        for (int i = 0; i < 63; i++) put(2'd0, 12'h800);
        chk("t1_nodone_early", dcnt, 0);
        put(2'd0, 12'h800);
        chk("t1_done", done, 4'b0001);
        chk("t1_a0_lat1", a0, 0);
        tick();
        chk("t1_a0", a0, 12'h800);
        chk("t1_done_clr", done, 0);
        chk("t1_a1", a1, 0);
        chk("t1_a2", a2, 0);
        chk("t1_a3", a3, 0);

        // 2: ramp truncation, then full scale
        for (int i = 0; i < 64; i++) put(2'd1, 12'(i));
        tick();
        chk("t2_ramp", a1, 12'h01F);
        block(2'd1, 12'hFFF);
        tick();
        chk("t2_full", a1, 12'hFFF);
        chk("t2_a0_kept", a0, 12'h800);

        // 3: round-robin with random gaps
        dcnt = 0;
        for (int i = 0; i < 256; i++) begin
            put(2'(i % 4), 12'((i % 4 + 1) * 256));
            repeat ($urandom_range(0, 2)) begin
                tick();
                if (done != 4'b0) dcnt++;
            end
        end
        tick();
        chk("t3_a0", a0, 12'h100);
        chk("t3_a1", a1, 12'h200);
        chk("t3_a2", a2, 12'h300);
        chk("t3_a3", a3, 12'h400);
        chk("t3_done_cnt", dcnt, 4);

        // 4: overwrite while frozen
        freeze = 1'b1;
        dcnt = 0;
        block(2'd2, 12'h111);
        tick();
        tick();
        chk("t4_hold1", a2, 12'h300);
        block(2'd2, 12'h222);
        tick();
        chk("t4_hold2", a2, 12'h300);
        chk("t4_done_cnt", dcnt, 2);
        freeze = 1'b0;
        chk("t4_prerel", a2, 12'h300);
        tick();
        chk("t4_rel", a2, 12'h222);
        chk("t4_no111", saw111, 0);

        // 5: async reset mid-block
        for (int i = 0; i < 40; i++) put(2'd3, 12'hABC);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_a0", a0, 0);
        chk("t5_a1", a1, 0);
        chk("t5_a2", a2, 0);
        chk("t5_a3", a3, 0);
        chk("t5_done", done, 0);
        tick();
        reset = 1'b1;
        tick();
        dcnt = 0;
        for (int i = 0; i < 63; i++) put(2'd3, 12'h010);
        chk("t5_no_residue", dcnt, 0);
        put(2'd3, 12'h010);
        tick();
        chk("t5_a3", a3, 12'h010);

        // 6: completion on the edge freeze falls
        freeze = 1'b1;
        block(2'd0, 12'h050);
        for (int i = 0; i < 63; i++) put(2'd0, 12'h0A0);
        chk("t6_hold", a0, 0);
        freeze = 1'b0;
        put(2'd0, 12'h0A0);
        chk("t6_old", a0, 12'h050);
        chk("t6_done", done, 4'b0001);
        tick();
        chk("t6_new", a0, 12'h0A0);
        tick();
        chk("t6_stable", a0, 12'h0A0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
